// File: rtl/afns_pkg.sv
// Shared constants and FSM state encoding for the AFNS TSV receive path.
package afns_pkg;
    localparam int NTSV_5_4 = 9;
    localparam int NRED_5_4 = 4;
    localparam int DLEN_5_4 = 7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/afns_popcount.sv
// afns_popcount: counts faulty TSVs, derives the enabled count and the too-many-faults flag.
// Latency: purely combinational.
// Backpressure: none; follows its input directly.
module afns_popcount #(
    parameter int NTSV = 9,
    parameter int NRED = 4
) (
    input  logic [NTSV-1:0]           f_flag,
    output logic [$clog2(NTSV+1)-1:0] en_cnt,
    output logic                      cfg_err
);
    localparam int CW = $clog2(NTSV+1);

    logic [CW-1:0] fault_cnt;

    always_comb begin
        fault_cnt = '0;
        for (int i = 0; i < NTSV; i++) begin
            fault_cnt = fault_cnt + CW'(f_flag[i]);
        end
    end

    assign en_cnt  = CW'(NTSV) - fault_cnt;
    assign cfg_err = (fault_cnt > CW'(NRED));
endmodule

// File: rtl/afns_serial_rx.sv
// afns_serial_rx: walks a captured TSV word one position per cycle, Fibonacci-decoding enabled TSVs.
// Latency: out_valid rises NTSV+1 cycles after the accepting edge.
// Backpressure: one word in flight; in_ready stays low until the result is taken via out_ready.
module afns_serial_rx
    import afns_pkg::*;
#(
    parameter int NTSV = NTSV_5_4,
    parameter int NRED = NRED_5_4,
    parameter int DLEN = DLEN_5_4
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NTSV-1:0]           tsv_in,
    input  logic [NTSV-1:0]           f_flag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DLEN-1:0]           data_out,
    output logic                      code_err,
    output logic                      ovf_err,
    output logic                      cfg_err,
    output logic [$clog2(NTSV+1)-1:0] n_enabled
);
    localparam int AW = DLEN + 2;
    localparam int CW = $clog2(NTSV+1);

    logic [1:0]      state;
    logic [NTSV-1:0] tsv_q;
    logic [NTSV-1:0] f_q;
    logic [CW-1:0]   idx;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   fa;
    logic [AW-1:0]   fb;
    logic            prev_one;

    logic [AW:0]     acc_sum;
    logic [AW:0]     fib_sum;
    logic [AW-1:0]   acc_add;
    logic [AW-1:0]   fib_add;
    logic            acc_ovf;
    logic            cur_bit;
    logic            cur_en;
    logic [CW-1:0]   en_cnt;
    logic            pc_cfg_err;

    afns_popcount #(.NTSV(NTSV), .NRED(NRED)) u_popcount (
        .f_flag  (f_q),
        .en_cnt  (en_cnt),
        .cfg_err (pc_cfg_err)
    );

    // Saturating adders: a carry out pins the result at all-ones instead of wrapping.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, fa};
        fib_sum = {1'b0, fa} + {1'b0, fb};
        acc_add = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
        fib_add = fib_sum[AW] ? '1 : fib_sum[AW-1:0];
    end

    assign acc_ovf  = |acc[AW-1:DLEN];
    assign cur_bit  = tsv_q[idx];
    assign cur_en   = ~f_q[idx];
    assign in_ready = (state == IDLE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tsv_q     <= '0;
            f_q       <= '0;
            idx       <= '0;
            acc       <= '0;
            fa        <= '0;
            fb        <= '0;
            prev_one  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            code_err  <= 1'b0;
            ovf_err   <= 1'b0;
            cfg_err   <= 1'b0;
            n_enabled <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tsv_q     <= tsv_in;
                        f_q       <= f_flag;
                        idx       <= '0;
                        acc       <= '0;
                        fa        <= AW'(1);
                        fb        <= AW'(2);
                        prev_one  <= 1'b0;
                        code_err  <= 1'b0;
                        ovf_err   <= 1'b0;
                        cfg_err   <= 1'b0;
                        n_enabled <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // Faulty positions consume a cycle but not a weight rank.
                    if (cur_en) begin
                        if (cur_bit) begin
                            acc <= acc_add;
                        end
                        code_err  <= code_err | (prev_one & cur_bit);
                        prev_one  <= cur_bit;
                        fa        <= fb;
                        fb        <= fib_add;
                        n_enabled <= n_enabled + CW'(1);
                    end
                    if (idx == CW'(NTSV-1)) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        ovf_err   <= acc_ovf;
                        data_out  <= acc_ovf ? '1 : acc[DLEN-1:0];
                        cfg_err   <= pc_cfg_err;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_nen_consistent: assert property (@(posedge clock) disable iff (!rst_n)
        out_valid |-> (n_enabled == en_cnt));
endmodule
